tmr_fault_monitor: RTL

- Sequential companion to the execute-stage TMR voter. The voter masks single-lane disagreement; this block decides what to do about it.
- Classifies each retiring comparison of lanes a/b/c and counts consecutive per-lane faults.
- When a lane's count reaches the threshold, runs a request/acknowledge handshake that has the pipeline resynchronise the faulty lane.
- Reports unmaskable (all-three-differ) events as a sticky fatal flag, and keeps a saturating error counter for CSR readout.

---
 rtl/tmr_fault_monitor_pkg.sv | 21 ++
 rtl/tmr_fault_monitor_if.sv | 32 +++
 rtl/tmr_fault_monitor_mismatch_detect.sv | 32 +++
 rtl/tmr_fault_monitor.sv | 136 +++++++++++++
 4 files changed

// File: rtl/tmr_fault_monitor_pkg.sv
// Shared types for the TMR fault monitor: FSM states, lane identifiers and
// common widths.
package tmr_fault_monitor_pkg;

  typedef enum logic [1:0] {
    TMR_IDLE,
    TMR_REQ,
    TMR_RESYNC,
    TMR_FATAL
  } tmrState_e;

  typedef enum logic [1:0] {
    LANE_A,
    LANE_B,
    LANE_C
  } tmrLane_e;

  localparam int NUM_LANES = 3;
  localparam int ERR_CNT_W = 32;

endpackage

// File: rtl/tmr_fault_monitor_if.sv
// Lane sample, resync handshake and status bundle between the execute-stage
// voter/pipeline (master) and the fault monitor (slave).
interface tmr_fault_monitor_if
  import tmr_fault_monitor_pkg::*;
#(
  parameter int unsigned SIG_W = 32
);

  logic                 valid_i;
  logic [SIG_W-1:0]     sig_a_i;
  logic [SIG_W-1:0]     sig_b_i;
  logic [SIG_W-1:0]     sig_c_i;
  logic                 resync_ack_i;
  logic                 clear_i;
  logic [NUM_LANES-1:0] lane_err_o;
  logic [NUM_LANES-1:0] lane_faulty_o;
  logic                 resync_req_o;
  logic                 resync_busy_o;
  logic                 fatal_o;
  logic [ERR_CNT_W-1:0] err_count_o;

  modport master (
    output valid_i, sig_a_i, sig_b_i, sig_c_i, resync_ack_i, clear_i,
    input  lane_err_o, lane_faulty_o, resync_req_o, resync_busy_o, fatal_o, err_count_o
  );

  modport slave (
    input  valid_i, sig_a_i, sig_b_i, sig_c_i, resync_ack_i, clear_i,
    output lane_err_o, lane_faulty_o, resync_req_o, resync_busy_o, fatal_o, err_count_o
  );

endinterface

// File: rtl/tmr_fault_monitor_mismatch_detect.sv
// Combinational classifier: flags the single disagreeing lane, or an
// uncorrectable sample when all three signatures differ.
module tmr_mismatch_detect
  import tmr_fault_monitor_pkg::*;
#(
  parameter int unsigned SIG_W = 32
) (
  input  logic [SIG_W-1:0]     sig_a,
  input  logic [SIG_W-1:0]     sig_b,
  input  logic [SIG_W-1:0]     sig_c,
  output logic [NUM_LANES-1:0] lane_bad,
  output logic                 uncorrectable
);

  logic ab_eq;
  logic ac_eq;
  logic bc_eq;

  assign ab_eq = (sig_a == sig_b);
  assign ac_eq = (sig_a == sig_c);
  assign bc_eq = (sig_b == sig_c);

  always_comb begin
    lane_bad         = '0;
    lane_bad[LANE_A] = !ab_eq && !ac_eq &&  bc_eq;
    lane_bad[LANE_B] = !ab_eq &&  ac_eq && !bc_eq;
    lane_bad[LANE_C] =  ab_eq && !ac_eq && !bc_eq;
  end

  assign uncorrectable = !ab_eq && !ac_eq && !bc_eq;

endmodule

// File: rtl/tmr_fault_monitor.sv
// Tracks consecutive per-lane TMR faults, drives the lane resync handshake,
// and reports uncorrectable mismatches plus a saturating error count.
module tmr_fault_monitor
  import tmr_fault_monitor_pkg::*;
#(
  parameter int unsigned SIG_W         = 32,
  parameter int unsigned THRESHOLD     = 4,
  parameter int unsigned RESYNC_CYCLES = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  tmr_fault_monitor_if.slave bus
);

  localparam int unsigned     CNT_W    = $clog2(THRESHOLD + 1);
  localparam int unsigned     TMR_W    = $clog2(RESYNC_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(THRESHOLD);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RESYNC_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [ERR_CNT_W-1:0] sat_inc_err(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

  tmrState_e            state_q;
  tmrState_e            state_d;
  logic [NUM_LANES-1:0] lane_bad;
  logic                 uncorr;
  logic [CNT_W-1:0]     cnt_q [NUM_LANES];
  logic [CNT_W-1:0]     cnt_d [NUM_LANES];
  logic [NUM_LANES-1:0] hit;
  logic [NUM_LANES-1:0] faulty_q;
  logic [NUM_LANES-1:0] lane_err_p1;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic [TMR_W-1:0]     timer_q;
  logic                 idle_sample;
  logic                 sample_bad;
  logic                 go_fatal;
  logic                 timer_done;
  logic                 resync_exit;

  tmr_mismatch_detect #(.SIG_W(SIG_W)) u_detect (
    .sig_a         (bus.sig_a_i),
    .sig_b         (bus.sig_b_i),
    .sig_c         (bus.sig_c_i),
    .lane_bad      (lane_bad),
    .uncorrectable (uncorr)
  );

  assign idle_sample = bus.valid_i && (state_q == TMR_IDLE);
  assign go_fatal    = bus.valid_i && uncorr;
  assign sample_bad  = bus.valid_i && ((|lane_bad) || uncorr);
  assign timer_done  = (timer_q == TMR_LAST);
  // Fatal pre-empts a resync exit, so counters and faulty flags stay frozen.
  assign resync_exit = (state_q == TMR_RESYNC) && timer_done && !go_fatal;

  // Consecutive-fault counters: only idle samples move them.
  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      cnt_d[l] = cnt_q[l];
      if (bus.clear_i || resync_exit) begin
        cnt_d[l] = '0;
      end else if (idle_sample) begin
        cnt_d[l] = lane_bad[l] ? sat_inc_cnt(cnt_q[l]) : '0;
      end
      hit[l] = idle_sample && (cnt_d[l] == CNT_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= TMR_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TMR_IDLE:   if (|hit)             state_d = TMR_REQ;
      TMR_REQ:    if (bus.resync_ack_i) state_d = TMR_RESYNC;
      TMR_RESYNC: if (timer_done)       state_d = TMR_IDLE;
      default:                          state_d = TMR_FATAL;
    endcase
    if (go_fatal) state_d = TMR_FATAL;
  end

  always_comb begin
    bus.resync_req_o  = 1'b0;
    bus.resync_busy_o = 1'b0;
    bus.fatal_o       = 1'b0;
    case (state_q)
      TMR_REQ: begin
        bus.resync_req_o  = 1'b1;
        bus.resync_busy_o = 1'b1;
      end
      TMR_RESYNC: bus.resync_busy_o = 1'b1;
      TMR_FATAL:  bus.fatal_o       = 1'b1;
      default: ;
    endcase
  end

  // Sample -> registered status stage.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q       <= '{default: '0};
      timer_q     <= '0;
      lane_err_p1 <= '0;
      err_cnt_q   <= '0;
      faulty_q    <= '0;
    end else begin
      cnt_q       <= cnt_d;
      timer_q     <= (state_q == TMR_RESYNC) ? timer_q + TMR_W'(1) : '0;
      lane_err_p1 <= bus.valid_i ? lane_bad : '0;
      if (bus.clear_i) begin
        err_cnt_q <= '0;
      end else if (sample_bad) begin
        err_cnt_q <= sat_inc_err(err_cnt_q);
      end
      if (resync_exit) begin
        faulty_q <= '0;
      end else if ((state_q == TMR_IDLE) && (state_d == TMR_REQ)) begin
        faulty_q <= hit;
      end
    end
  end

  assign bus.lane_err_o    = lane_err_p1;
  assign bus.lane_faulty_o = faulty_q;
  assign bus.err_count_o   = err_cnt_q;

endmodule
